system_ram: RTL and testbench



---
 rtl/system_ram_pkg.sv | 14 +
 rtl/ram_bank.sv | 47 ++++
 rtl/system_ram.sv | 69 ++++++
 tb/tb_system_ram.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/system_ram_pkg.sv
// Shared sizes, bank index type and reset value for the banked data RAM.
// Write-through behaviour is selected with SYSTEM_RAM_WRITE_THROUGH_EN (see ram_bank).
package system_ram_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int BANK_SEL_W = 2;
    localparam int NUM_BANKS  = 4;

    typedef logic [BANK_SEL_W-1:0] bank_idx_t;

    localparam logic [DATA_W_DEF-1:0] Q_RST_VAL = '0;

endpackage : system_ram_pkg

// File: rtl/ram_bank.sv
// One RAM bank: word array plus registered read port cleared by async reset.
// SYSTEM_RAM_WRITE_THROUGH_EN defined: a write also loads the output register.
module ram_bank
    import system_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = ADDR_W_DEF - BANK_SEL_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clkEn,
    input  logic              writeEn,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] out_q;

    // Array has no reset so contents survive nrst; an access during reset is dropped.
    always_ff @(posedge clk) begin
        if (nrst && clkEn && writeEn) begin
            mem[idx] <= data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q <= DATA_W'(Q_RST_VAL);
        end else if (clkEn) begin
            if (!writeEn) begin
                out_q <= mem[idx];
            end
`ifdef SYSTEM_RAM_WRITE_THROUGH_EN
            else begin
                out_q <= data;
            end
`endif
        end
    end

    assign rdata = out_q;

endmodule : ram_bank

// File: rtl/system_ram.sv
// 1024 x 32 single-port data RAM built from four banks with demux/registered mux.
// Write-through on write cycles is enabled by defining SYSTEM_RAM_WRITE_THROUGH_EN.
module system_ram
    import system_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clkEn,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] Q
);

    localparam int IDX_W = ADDR_W - BANK_SEL_W;

    if (ADDR_W < 3) begin : g_bad_addr_w
        $error("system_ram: ADDR_W must be 3 or more");
    end

    bank_idx_t         bank_sel;
    logic [IDX_W-1:0]  word_idx;
    bank_idx_t         sel_q;
    bank_idx_t         sel_d;

    logic              en_b   [NUM_BANKS];
    logic              we_b   [NUM_BANKS];
    logic [DATA_W-1:0] data_b [NUM_BANKS];
    logic [DATA_W-1:0] rdata  [NUM_BANKS];

    assign bank_sel = addr[ADDR_W-1 -: BANK_SEL_W];
    assign word_idx = addr[IDX_W-1:0];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign en_b[b]   = clkEn && (bank_sel == BANK_SEL_W'(b));
        assign we_b[b]   = en_b[b] && writeEn;
        assign data_b[b] = en_b[b] ? data : '0;

        ram_bank #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_bank (
            .clk     (clk),
            .nrst    (nrst),
            .clkEn   (en_b[b]),
            .writeEn (we_b[b]),
            .idx     (word_idx),
            .data    (data_b[b]),
            .rdata   (rdata[b])
        );
    end

    assign sel_d = clkEn ? bank_sel : sel_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Select follows the registered bank number, never the live address.
    assign Q = rdata[sel_q];

endmodule : system_ram

// File: tb/tb_system_ram.sv
// Directed self-checking bench for system_ram (either SYSTEM_RAM_WRITE_THROUGH_EN setting).
module tb_system_ram;

    logic        clk;
    logic        nrst;
    logic        clkEn;
    logic        writeEn;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] Q;

    int n_tests = 0;
    int n_fail  = 0;

    system_ram dut (
        .clk     (clk),
        .nrst    (nrst),
        .clkEn   (clkEn),
        .writeEn (writeEn),
        .addr    (addr),
        .data    (data),
        .Q       (Q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic we, input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        clkEn   = 1'b1;
        writeEn = we;
        addr    = a;
        data    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
        access(1'b0, a, 32'h0);
        chk(tag, Q, exp);
    endtask

    logic [9:0]  wa [5] = '{10'h001, 10'h101, 10'h201, 10'h301, 10'h3FF};
    logic [31:0] wd [5] = '{32'hAAAA0001, 32'hBBBB0101, 32'hCCCC0201, 32'hDDDD0301, 32'hEEEE03FF};

    initial begin
        int bad;
        nrst    = 1'b0;
        clkEn   = 1'b1;
        writeEn = 1'b0;
        addr    = 10'd5;
        data    = 32'h0;

        // Reset held with an active read request
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_q", Q, 32'h0);
        end

        // First edge after release performs the write of addr 5
        @(negedge clk);
        writeEn = 1'b1;
        data    = 32'h55550005;
        nrst    = 1'b1;
        @(posedge clk);
        #1;
`ifdef SYSTEM_RAM_WRITE_THROUGH_EN
        chk("first_write_q", Q, 32'h55550005);
`else
        chk("first_write_q", Q, 32'h0);
`endif
        rd("read_5", 10'd5, 32'h55550005);

        // Bank isolation plus the top word
        for (int i = 0; i < 5; i++) access(1'b1, wa[i], wd[i]);
        for (int i = 0; i < 5; i++) rd($sformatf("iso_%0d", i), wa[i], wd[i]);

        // Back-to-back reads across banks
        rd("b2b_001", 10'h001, 32'hAAAA0001);
        rd("b2b_101", 10'h101, 32'hBBBB0101);
        rd("b2b_3ff", 10'h3FF, 32'hEEEE03FF);

        // Hold: disabled sweep with writeEn high must change nothing
        rd("hold_pre", 10'h101, 32'hBBBB0101);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            clkEn   = 1'b0;
            writeEn = 1'b1;
            addr    = i[9:0];
            data    = 32'hF0F00000 | i;
            @(posedge clk);
            #1;
            if (Q !== 32'hBBBB0101) bad++;
        end
        chk("hold_sweep", bad, 32'd0);
        chk("hold_end_q", Q, 32'hBBBB0101);
        rd("hold_rd_005", 10'h005, 32'h55550005);
        for (int i = 0; i < 5; i++) rd($sformatf("hold_rd_%0d", i), wa[i], wd[i]);

        // Write cycle right after a read of bank 1; bank 0 last read 0x001
        rd("wc_pre", 10'h101, 32'hBBBB0101);
        access(1'b1, 10'h010, 32'h12345678);
`ifdef SYSTEM_RAM_WRITE_THROUGH_EN
        chk("wc_q", Q, 32'h12345678);
`else
        chk("wc_q", Q, 32'hAAAA0001);
`endif
        rd("wc_readback", 10'h010, 32'h12345678);

        // Mid-operation reset with a coincident write request
        rd("mr_pre", 10'h201, 32'hCCCC0201);
        @(negedge clk);
        clkEn   = 1'b1;
        writeEn = 1'b1;
        addr    = 10'h201;
        data    = 32'hDEADBEEF;
        #2;
        nrst = 1'b0;
        #1;
        chk("mr_async_q", Q, 32'h0);
        @(posedge clk);
        #1;
        chk("mr_edge_q", Q, 32'h0);
        @(negedge clk);
        writeEn = 1'b0;
        nrst    = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_release_rd", Q, 32'hCCCC0201);
        rd("mr_reread", 10'h201, 32'hCCCC0201);
        rd("mr_other", 10'h301, 32'hDDDD0301);

        // clkEn low after a read: Q holds while addr moves
        @(negedge clk);
        clkEn   = 1'b0;
        writeEn = 1'b0;
        addr    = 10'h001;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold", Q, 32'hDDDD0301);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_system_ram
